// File: rtl/banner_pkg.sv
// Shared constants for the banner controller: FSM state encodings and the
// default debounce length (1 ms at 1 GHz-class clocks, ~10 ms at 100 MHz).
package banner_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_CLEAR = 2'b11;

    localparam int DB_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchroniser, stable-level debouncer
// and a one-cycle press pulse on each accepted rising level.
module btn_debounce
    import banner_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_TERM = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          db;
    logic          db_d;
    logic [CW-1:0] cnt;

    // Synchronise the raw button, then accept a new level only after it has
    // disagreed with the debounced level for DB_CYCLES consecutive samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            db_d  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            db_d  <= db;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_TERM) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Releases produce nothing; only the rising debounced edge is a press.
    assign press = db & ~db_d;

endmodule

// File: rtl/banner_ctrl.sv
// Push-button sequencer for the scrolling banner: debounces run/dir/clear
// buttons and drives the banner's enable, dir and clear strobe from a
// four-state FSM (IDLE, RUN, PAUSE, CLEAR).
// Optional feature: define BANNER_CTRL_AUTO_REV_EN to flip dir automatically
// every AUTO_REV_CYCLES cycles spent in RUN.
module banner_ctrl
    import banner_pkg::*;
#(
    parameter int DB_CYCLES       = DB_CYCLES_DEF,
    parameter int AUTO_REV_CYCLES = 2**24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_dir,
    input  logic       btn_clr,
    output logic       enable,
    output logic       dir,
    output logic       banner_reset,
    output logic [1:0] state
);

    logic       run_p;
    logic       dir_p;
    logic       clr_p;
    logic [1:0] state_nxt;
    logic       dir_tog;
    logic       auto_tog;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_run),
        .press (run_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_dir),
        .press (dir_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clr),
        .press (clr_p)
    );

    // Next state and manual dir toggle; clear wins over run and swallows a
    // same-cycle dir press, and CLEAR itself ignores every press.
    always_comb begin
        state_nxt = state;
        dir_tog   = 1'b0;
        if (state == ST_CLEAR) begin
            state_nxt = ST_IDLE;
        end else begin
            dir_tog = dir_p & ~clr_p;
            if (clr_p) begin
                state_nxt = ST_CLEAR;
            end else if (run_p) begin
                state_nxt = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
            end
        end
    end

`ifdef BANNER_CTRL_AUTO_REV_EN
    localparam int AW = $clog2(AUTO_REV_CYCLES);
    localparam logic [AW-1:0] AR_TERM = AW'(AUTO_REV_CYCLES - 1);

    logic [AW-1:0] run_cnt;

    assign auto_tog = (state == ST_RUN) && (run_cnt == AR_TERM);

    // Count RUN cycles (held in PAUSE); restart after each flip, after a
    // manual dir press, and whenever the banner is idle or being cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (state == ST_IDLE || state == ST_CLEAR || dir_tog) begin
            run_cnt <= '0;
        end else if (state == ST_RUN) begin
            run_cnt <= auto_tog ? '0 : run_cnt + 1'b1;
        end
    end
`else
    logic unused_auto_rev;

    assign auto_tog        = 1'b0;
    assign unused_auto_rev = (AUTO_REV_CYCLES != 0);
`endif

    // Registered outputs: decoded from the next state so enable and the
    // clear strobe line up with the state register, with no input-to-output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            enable       <= 1'b0;
            banner_reset <= 1'b0;
            dir          <= 1'b0;
        end else begin
            state        <= state_nxt;
            enable       <= (state_nxt == ST_RUN);
            banner_reset <= (state_nxt == ST_CLEAR);
            dir          <= dir ^ (dir_tog | auto_tog);
        end
    end

endmodule

// File: tb/tb_banner_ctrl.sv
// Directed bench for banner_ctrl with DB_CYCLES=4, AUTO_REV_CYCLES=16.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_banner_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_run;
    logic       btn_dir;
    logic       btn_clr;
    logic       enable;
    logic       dir;
    logic       banner_reset;
    logic [1:0] state;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [2:0] B_RUN = 3'b001;
    localparam logic [2:0] B_DIR = 3'b010;
    localparam logic [2:0] B_CLR = 3'b100;

    banner_ctrl #(.DB_CYCLES(4), .AUTO_REV_CYCLES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_run      (btn_run),
        .btn_dir      (btn_dir),
        .btn_clr      (btn_clr),
        .enable       (enable),
        .dir          (dir),
        .banner_reset (banner_reset),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [2:0] m);
        btn_run = m[0];
        btn_dir = m[1];
        btn_clr = m[2];
    endtask

    // Hold buttons for 'hold' cycles, release, and wait out the release debounce.
    task automatic push(input logic [2:0] m, input int hold);
        set_btn(m);
        tick(hold);
        set_btn(3'b000);
        tick(7);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_btn(3'b000);
        tick(3);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_btn(3'b000);
        tick(3);
        check("rst_outs", {27'd0, enable, dir, banner_reset, state}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check("idle_stable", {27'd0, enable, dir, banner_reset, state}, 32'd0);
        end

        // Run press latency: enable rises on the 7th edge after the raw rise.
        btn_run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("en_latency_low", {31'd0, enable}, 32'd0);
        end
        tick(1);
        check("en_latency_high", {31'd0, enable}, 32'd1);
        check("state_run", {30'd0, state}, 32'd1);
        tick(3);
        btn_run = 1'b0;
        tick(10);
        check("release_noop", {30'd0, state}, 32'd1);

        // 3-cycle glitch is rejected.
        btn_run = 1'b1;
        tick(3);
        btn_run = 1'b0;
        tick(10);
        check("glitch_state", {30'd0, state}, 32'd1);
        check("glitch_en", {31'd0, enable}, 32'd1);

        // Pause and resume.
        push(B_RUN, 7);
        check("pause_state", {30'd0, state}, 32'd2);
        check("pause_en", {31'd0, enable}, 32'd0);
        push(B_RUN, 7);
        check("resume_state", {30'd0, state}, 32'd1);
        check("resume_en", {31'd0, enable}, 32'd1);

        // Run and clear together in RUN: clear wins, one-cycle strobe.
        set_btn(B_RUN | B_CLR);
        tick(6);
        check("pre_clr_state", {30'd0, state}, 32'd1);
        tick(1);
        check("clr_state", {30'd0, state}, 32'd3);
        check("clr_strobe", {31'd0, banner_reset}, 32'd1);
        check("clr_en", {31'd0, enable}, 32'd0);
        tick(1);
        check("post_clr_state", {30'd0, state}, 32'd0);
        check("post_clr_strobe", {31'd0, banner_reset}, 32'd0);
        check("post_clr_en", {31'd0, enable}, 32'd0);
        tick(1);
        check("clr_idle_hold", {30'd0, state}, 32'd0);
        set_btn(3'b000);
        tick(7);
        check("clr_release", {30'd0, state}, 32'd0);

        // Reset mid-operation aborts the FSM immediately.
        push(B_RUN, 7);
        check("run_again", {30'd0, state}, 32'd1);
        reset = 1'b1;
        tick(1);
        check("midrst_state", {30'd0, state}, 32'd0);
        check("midrst_en", {31'd0, enable}, 32'd0);
        do_reset();

        // Reach PAUSE with 14 RUN cycles (below the auto-reverse period).
        push(B_RUN, 7);
        push(B_RUN, 7);
        check("dir_pause_state", {30'd0, state}, 32'd2);
        check("dir_pause_init", {31'd0, dir}, 32'd0);
        push(B_DIR, 7);
        check("dir_toggle", {31'd0, dir}, 32'd1);
        check("dir_keep_pause", {30'd0, state}, 32'd2);

        // Dir together with clear is discarded; dir survives the clear.
        push(B_DIR | B_CLR, 7);
        check("dirclr_dir", {31'd0, dir}, 32'd1);
        check("dirclr_state", {30'd0, state}, 32'd0);
        push(B_DIR, 7);
        check("dir_idle_toggle", {31'd0, dir}, 32'd0);

`ifdef BANNER_CTRL_AUTO_REV_EN
        // 16 RUN cycles flip dir.
        do_reset();
        btn_run = 1'b1;
        tick(7);
        check("ar_run", {30'd0, state}, 32'd1);
        btn_run = 1'b0;
        tick(15);
        check("ar_before", {31'd0, dir}, 32'd0);
        tick(1);
        check("ar_flip", {31'd0, dir}, 32'd1);

        // 13 RUN, 20+ PAUSE, then RUN: counter holds, flips on 16th RUN cycle only.
        do_reset();
        btn_run = 1'b1;
        tick(7);
        btn_run = 1'b0;
        tick(6);
        btn_run = 1'b1;
        tick(7);
        check("ar_paused", {30'd0, state}, 32'd2);
        btn_run = 1'b0;
        tick(20);
        check("ar_pause_hold", {31'd0, dir}, 32'd0);
        btn_run = 1'b1;
        tick(7);
        check("ar_resumed", {30'd0, state}, 32'd1);
        tick(2);
        check("ar_resume_before", {31'd0, dir}, 32'd0);
        tick(1);
        check("ar_resume_flip", {31'd0, dir}, 32'd1);
        btn_run = 1'b0;
        tick(10);
        check("ar_once", {31'd0, dir}, 32'd1);
`else
        // Without auto-reverse, 100 RUN cycles leave dir alone.
        do_reset();
        btn_run = 1'b1;
        tick(7);
        check("noar_run", {30'd0, state}, 32'd1);
        btn_run = 1'b0;
        tick(100);
        check("noar_dir", {31'd0, dir}, 32'd0);
        check("noar_state", {30'd0, state}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/banner_ctrl.md
# banner_ctrl

User-facing sequencer for the 4-digit scrolling banner. Takes three raw push-buttons (run/pause, direction, clear), synchronises and debounces them, and drives the banner's `enable`, `dir` and a dedicated clear-reset strobe from a small state machine. Sits between board buttons and the banner; the banner's own shift timer is untouched.

## Interface
- `DB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level change; must be ≥ 2.
- `AUTO_REV_CYCLES`, default 2**24: RUN cycles between automatic direction flips; used only with `BANNER_CTRL_AUTO_REV_EN`.
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `btn_run`  in  1  raw, asynchronous, active-high run/pause button.
- `btn_dir`  in  1  raw, asynchronous, active-high direction-toggle button.
- `btn_clr`  in  1  raw, asynchronous, active-high clear button.
- `enable`  out  1  to banner `enable`; high only in RUN.
- `dir`  out  1  to banner `dir`; 1 = leftward, 0 = rightward.
- `banner_reset`  out  1  one-cycle pulse to banner `reset`, ORed externally with system reset.
- `state`  out  2  current FSM state, for LEDs.

## Operation
- Each button: 2-flop synchroniser → debouncer (level `db`, counter `cnt`). Sync output equal to `db` → `cnt` cleared; different and `cnt == DB_CYCLES-1` → `db` takes the new value, `cnt` cleared; otherwise `cnt` increments. Any agreeing sample restarts the count.
- Press pulse = `db & ~db_d`: exactly one cycle per accepted press. Releases generate nothing.
- FSM, encoding IDLE=00, RUN=01, PAUSE=10, CLEAR=11:
  - IDLE: run → RUN; clr → CLEAR.
  - RUN: run → PAUSE; clr → CLEAR.
  - PAUSE: run → RUN; clr → CLEAR.
  - CLEAR: unconditionally → IDLE next cycle; all presses in this cycle are discarded.
- Priority within one cycle: clr beats run; a dir press in the same cycle as clr is discarded.
- Dir press in IDLE, RUN or PAUSE toggles `dir`. The toggle applies immediately; the banner samples it at its next shift tick.
- `dir` survives CLEAR; only `reset` returns it to 0.
- `enable` = (state == RUN); `banner_reset` = (state == CLEAR). Both are registered outputs, so no combinational path from any input.

## Timing
- Reset values: `enable`=0, `dir`=0, `banner_reset`=0, `state`=IDLE. Synchroniser flops, `db`, `db_d`, debounce counters and the auto-reverse counter all clear to 0.
- Button latency: raw rise → press pulse after 2 + DB_CYCLES edges. Outputs update on the next edge, for a total of 2 + DB_CYCLES + 1 edges.
- `banner_reset` is high for exactly one cycle. `enable` is 0 during that cycle and during the following IDLE.
- Reset mid-operation aborts debounce and FSM immediately. A button held through reset produces a press DB_CYCLES+2 cycles after reset deasserts, because `db` restarts at 0.
- Debounce counter width: $clog2(DB_CYCLES). Auto-reverse counter width: $clog2(AUTO_REV_CYCLES). Both are compared with `==`, with no overflow past terminal count.

## Configuration
- `BANNER_CTRL_AUTO_REV_EN` defined:
  - A run counter increments each RUN cycle, holds in PAUSE, and clears in IDLE and CLEAR and on any manual dir press.
  - At AUTO_REV_CYCLES-1 it toggles `dir` on the next edge and clears.
  - If a manual dir press coincides with terminal count, `dir` toggles once only and the counter clears.
- Undefined: no counter is present, `AUTO_REV_CYCLES` is ignored, and `dir` changes only on a dir press.

## Structure
- Shared package `banner_pkg`: FSM state encodings (IDLE/RUN/PAUSE/CLEAR) and the default DB_CYCLES constant.
- Sub-module `btn_debounce` (synchroniser + debouncer + press pulse), parameterised by DB_CYCLES and instantiated three times. FSM and auto-reverse stay in `banner_ctrl`.

## Test plan
Use DB_CYCLES=4 and AUTO_REV_CYCLES=16.
- Reset held 3 cycles, then released, no buttons → `enable`=0, `dir`=0, `banner_reset`=0, `state`=00, stable for 50 cycles.
- `btn_run` high 10 cycles from IDLE → `enable` rises exactly 7 edges after `btn_run` rises and `state`=01. A 3-cycle `btn_run` glitch → no change.
- Debounced run press in RUN → `state`=10, `enable`=0. A second press → `state`=01, `enable`=1. Releases cause no transitions.
- `btn_run` and `btn_clr` rise together in RUN → single-cycle `banner_reset`=1 with `state`=11, then `state`=00, `enable`=0, `dir` unchanged.
- Dir press in PAUSE → `dir` 0→1 and `state` stays 10. A dir press simultaneous with clr → `dir` unchanged.
- Macro defined, 16 RUN cycles → `dir` toggles. 8 RUN + pause 20 + 8 RUN → `dir` toggles exactly once. Macro undefined, 100 RUN cycles → `dir` constant.
